fifo_wr_sched: RTL and testbench

Write-side scheduler for the flushable FIFO. It shares the FIFO write port among N requesters with round-robin arbitration, and it sequences flushes. A flush request blocks writes, issues a one-cycle flush pulse, then holds a quiet window so the flushed pointers can settle across the clock domain before writes resume. It sits in the write-clock domain, directly in front of the FIFO write port.

---
 rtl/fifo_wr_sched_pkg.sv | 37 +++
 rtl/fifo_wr_sched_rr_arbiter.sv | 58 +++++
 rtl/fifo_wr_sched.sv | 123 ++++++++++++
 tb/tb_fifo_wr_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and helpers for the FIFO write-side scheduler: FSM state
// encoding, parameter defaults and the round-robin search function.
package fifo_wr_sched_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_QUIET = 2'd2
   } state_e;

   localparam int N_DEF     = 4;
   localparam int DW_DEF    = 4;
   localparam int QUIET_DEF = 3;
   localparam int CW_DEF    = 16;

   // First eligible index at or after ptr, wrapping modulo n (n <= 8).
   function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                          input logic [7:0] eligible,
                                          input int unsigned n);
      logic [2:0]  res;
      logic        found;
      int unsigned idx;
      res   = 3'd0;
      found = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         idx = ({29'd0, ptr} + k) % n;
         if ((k < n) && !found && eligible[idx[2:0]]) begin
            res   = idx[2:0];
            found = 1'b1;
         end else begin
            res   = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin arbiter: eligibility mask, rotating pointer and one-hot grant.
// The pointer only advances on a grant, so blocked cycles keep fairness.
module fifo_wr_sched_rr_arbiter
   import fifo_wr_sched_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en_i,
   input  logic         fifo_full_i,
   input  logic [N-1:0] req_valid_i,
   output logic [N-1:0] grant_o,
   output logic         grant_any_o
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  elig_s;
   logic [7:0]    elig8_s;
   logic [2:0]    ptr8_s;
   logic [2:0]    idx8_s;

   // Eligibility, grant search and pointer update.
   always_comb begin
      elig_s              = req_valid_i & {N{en_i & ~fifo_full_i}};
      elig8_s             = 8'd0;
      elig8_s[N-1:0]      = elig_s;
      ptr8_s              = 3'd0;
      ptr8_s[PW-1:0]      = ptr_q;
      idx8_s              = next_rr(ptr8_s, elig8_s, N);
      grant_any_o         = |elig_s;
      grant_o             = '0;
      ptr_d               = ptr_q;
      if (grant_any_o) begin
         grant_o[idx8_s[PW-1:0]] = 1'b1;
         if (idx8_s == 3'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = PW'(idx8_s + 3'd1);
         end
      end else begin
         grant_o = '0;
         ptr_d   = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler: round-robin sharing of the FIFO write port plus the
// flush sequencer (FLUSH pulse, then a QUIET window before writes resume).
module fifo_wr_sched
   import fifo_wr_sched_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DW    = DW_DEF,
   parameter int QUIET = QUIET_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [N-1:0]  req_valid_i,
   input  logic [N*DW-1:0] req_data_i,
   output logic [N-1:0]  req_ready_o,
   input  logic          flush_req_i,
   input  logic          fifo_full_i,
   output logic          fifo_wr_valid_o,
   output logic [DW-1:0] fifo_wr_data_o,
   output logic          fifo_flush_o,
   output logic          flush_busy_o,
   output logic          flush_done_o,
   output logic [CW-1:0] wr_count_o
);

   state_e        state_q, state_d;
   logic [3:0]    qcnt_q, qcnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_s;
   logic [N-1:0]  grant_s;
   logic          grant_any_s;
   logic [DW-1:0] data_s;

   // Reset is folded in so grants are suppressed while reset is held.
   assign run_s = (state_q == ST_RUN) & reset;

   fifo_wr_sched_rr_arbiter #(.N(N)) u_arb (
      .clock       (clock),
      .reset       (reset),
      .en_i        (run_s),
      .fifo_full_i (fifo_full_i),
      .req_valid_i (req_valid_i),
      .grant_o     (grant_s),
      .grant_any_o (grant_any_s)
   );

   // Flush sequencer next-state and decoded status outputs.
   always_comb begin
      state_d      = state_q;
      qcnt_d       = qcnt_q;
      fifo_flush_o = (state_q == ST_FLUSH);
      flush_busy_o = (state_q == ST_FLUSH) || (state_q == ST_QUIET);
      flush_done_o = (state_q == ST_QUIET) && (qcnt_q == 4'd0) && !flush_req_i;
      case (state_q)
         ST_RUN: begin
            if (flush_req_i) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d = ST_QUIET;
            qcnt_d  = 4'(QUIET - 1);
         end
         ST_QUIET: begin
            if (flush_req_i) begin
               state_d = ST_FLUSH;
            end else if (qcnt_q == 4'd0) begin
               state_d = ST_RUN;
            end else begin
               qcnt_d = qcnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            qcnt_d  = 4'd0;
         end
      endcase
   end

   // Accepted-write counter; cleared on entry to FLUSH so it reads 0 there.
   always_comb begin
      if ((state_d == ST_FLUSH) || (state_q == ST_FLUSH)) begin
         cnt_d = '0;
      end else if (grant_any_s && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // One-hot data mux for the granted requester.
   always_comb begin
      data_s = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_s[i]) begin
            data_s = data_s | req_data_i[i*DW +: DW];
         end else begin
            data_s = data_s;
         end
      end
   end

   assign req_ready_o     = grant_s;
   assign fifo_wr_valid_o = |(req_valid_i & grant_s);
   assign fifo_wr_data_o  = data_s;
   assign wr_count_o      = cnt_q;

   // State, quiet counter and write counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         qcnt_q  <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: a per-cycle vector table for arbitration
// and flush sequencing, then hand-written asynchronous reset sequences.
module tb_fifo_wr_sched;

   logic        clock;
   logic        reset;
   logic [3:0]  req_valid_i;
   logic [15:0] req_data_i;
   logic [3:0]  req_ready_o;
   logic        flush_req_i;
   logic        fifo_full_i;
   logic        fifo_wr_valid_o;
   logic [3:0]  fifo_wr_data_o;
   logic        fifo_flush_o;
   logic        flush_busy_o;
   logic        flush_done_o;
   logic [15:0] wr_count_o;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [3:0]  valid;
      logic        full;
      logic        flush;
      logic [3:0]  ready;
      logic [3:0]  data;
      logic        fl;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
   } vec_t;

   localparam int NV = 39;
   vec_t tbl [NV];

   fifo_wr_sched #(.N(4), .DW(4), .QUIET(3), .CW(16)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid_i     (req_valid_i),
      .req_data_i      (req_data_i),
      .req_ready_o     (req_ready_o),
      .flush_req_i     (flush_req_i),
      .fifo_full_i     (fifo_full_i),
      .fifo_wr_valid_o (fifo_wr_valid_o),
      .fifo_wr_data_o  (fifo_wr_data_o),
      .fifo_flush_o    (fifo_flush_o),
      .flush_busy_o    (flush_busy_o),
      .flush_done_o    (flush_done_o),
      .wr_count_o      (wr_count_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic [3:0] v, input logic f, input logic fr,
                               input logic [3:0] r, input logic [3:0] d, input logic fl,
                               input logic b, input logic dn, input logic [15:0] c);
      vec_t t;
      t.valid = v; t.full = f; t.flush = fr; t.ready = r; t.data = d;
      t.fl = fl; t.busy = b; t.done = dn; t.cnt = c;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string p, input logic [3:0] r, input logic [3:0] d,
                          input logic fl, input logic b, input logic dn, input logic [15:0] c);
      chk({p, " ready"}, 32'(req_ready_o), 32'(r));
      chk({p, " wr_valid"}, 32'(fifo_wr_valid_o), 32'(r != 4'd0));
      chk({p, " wr_data"}, 32'(fifo_wr_data_o), 32'(d));
      chk({p, " flush"}, 32'(fifo_flush_o), 32'(fl));
      chk({p, " busy"}, 32'(flush_busy_o), 32'(b));
      chk({p, " done"}, 32'(flush_done_o), 32'(dn));
      chk({p, " count"}, 32'(wr_count_o), 32'(c));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      // Requester data: 0->A, 1->B, 2->C, 3->D.
      tbl[0]  = mk(4'hF, 1'b0, 1'b0, 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd0);
      tbl[1]  = mk(4'hF, 1'b0, 1'b0, 4'b0010, 4'hB, 1'b0, 1'b0, 1'b0, 16'd1);
      tbl[2]  = mk(4'hF, 1'b0, 1'b0, 4'b0100, 4'hC, 1'b0, 1'b0, 1'b0, 16'd2);
      tbl[3]  = mk(4'hF, 1'b0, 1'b0, 4'b1000, 4'hD, 1'b0, 1'b0, 1'b0, 16'd3);
      tbl[4]  = mk(4'hF, 1'b0, 1'b0, 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd4);
      tbl[5]  = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd5);
      tbl[6]  = mk(4'h2, 1'b0, 1'b0, 4'b0010, 4'hB, 1'b0, 1'b0, 1'b0, 16'd5);
      tbl[7]  = mk(4'hA, 1'b0, 1'b0, 4'b1000, 4'hD, 1'b0, 1'b0, 1'b0, 16'd6);
      tbl[8]  = mk(4'hA, 1'b0, 1'b0, 4'b0010, 4'hB, 1'b0, 1'b0, 1'b0, 16'd7);
      tbl[9]  = mk(4'hA, 1'b0, 1'b0, 4'b1000, 4'hD, 1'b0, 1'b0, 1'b0, 16'd8);
      tbl[10] = mk(4'h1, 1'b0, 1'b0, 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd9);
      tbl[11] = mk(4'hF, 1'b1, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd10);
      tbl[12] = mk(4'hF, 1'b1, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd10);
      tbl[13] = mk(4'hF, 1'b1, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd10);
      tbl[14] = mk(4'hF, 1'b0, 1'b0, 4'b0010, 4'hB, 1'b0, 1'b0, 1'b0, 16'd10);
      tbl[15] = mk(4'h4, 1'b0, 1'b1, 4'b0100, 4'hC, 1'b0, 1'b0, 1'b0, 16'd11);
      tbl[16] = mk(4'h4, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      tbl[17] = mk(4'hF, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[18] = mk(4'hF, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[19] = mk(4'hF, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b1, 16'd0);
      tbl[20] = mk(4'hF, 1'b0, 1'b0, 4'b1000, 4'hD, 1'b0, 1'b0, 1'b0, 16'd0);
      tbl[21] = mk(4'h0, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd1);
      tbl[22] = mk(4'h0, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      tbl[23] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[24] = mk(4'h0, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[25] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      tbl[26] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[27] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[28] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b1, 16'd0);
      tbl[29] = mk(4'h0, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      tbl[30] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      tbl[31] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[32] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[33] = mk(4'h0, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[34] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      tbl[35] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[36] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[37] = mk(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b1, 16'd0);
      tbl[38] = mk(4'hF, 1'b0, 1'b0, 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd0);

      req_data_i  = 16'hDCBA;
      req_valid_i = 4'hF;
      flush_req_i = 1'b0;
      fifo_full_i = 1'b0;
      reset       = 1'b0;
      #12;
      chk_all("reset", 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         req_valid_i = tbl[i].valid;
         fifo_full_i = tbl[i].full;
         flush_req_i = tbl[i].flush;
         @(negedge clock);
         chk_all($sformatf("v%0d", i), tbl[i].ready, tbl[i].data, tbl[i].fl,
                 tbl[i].busy, tbl[i].done, tbl[i].cnt);
         @(posedge clock);
         #1;
      end

      // Asynchronous reset in the middle of a QUIET window.
      req_valid_i = 4'h0;
      flush_req_i = 1'b1;
      @(posedge clock);
      #1;
      flush_req_i = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #2;
      req_valid_i = 4'hF;
      chk("pre-reset busy", 32'(flush_busy_o), 32'd1);
      reset = 1'b0;
      #1;
      chk_all("async mid-quiet", 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      chk_all("post-reset c0", 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clock);
      #1;
      chk_all("post-reset c1", 4'b0010, 4'hB, 1'b0, 1'b0, 1'b0, 16'd1);
      @(posedge clock);
      #1;
      chk_all("post-reset c2", 4'b0100, 4'hC, 1'b0, 1'b0, 1'b0, 16'd2);

      // Asynchronous reset in RUN with a non-zero count.
      reset = 1'b0;
      #1;
      chk_all("async in run", 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      chk_all("post-reset2", 4'b0001, 4'hA, 1'b0, 1'b0, 1'b0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
